// File: rtl/fifo_pkg.sv
// Shared types for the FIFO consumer blocks.
package fifo_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} burst_rd_state_t;

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from a FIFO pop interface onto a registered valid/ready stream.
// Sustains one beat per cycle; pops only when the output register is free or being emptied.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MaxBurst   = 256,
  parameter int unsigned BurstWidth = $clog2(MaxBurst) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [BurstWidth-1:0] burst_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BurstWidth-1:0] count_o,
  input  logic                  fifo_empty_i,
  input  logic [DataWidth-1:0]  fifo_data_i,
  output logic                  fifo_pop_o,
  output logic [DataWidth-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  burst_rd_state_t       state_q, state_d;
  logic [BurstWidth-1:0] remaining_q;
  logic [BurstWidth-1:0] count_q;
  logic [DataWidth-1:0]  data_q;
  logic                  valid_q;
  logic                  handoff;

  assign handoff = valid_q & ready_i;

  always_comb begin
    state_d    = state_q;
    fifo_pop_o = (state_q == READ) && (remaining_q != '0) && !fifo_empty_i && !clr_i &&
                 (!valid_q || ready_i);
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = (burst_len_i != '0) ? READ : DONE;
      end
      // Leave READ one cycle after the last pop so that beat reaches the output register.
      READ: begin
        if (remaining_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (!valid_q || handoff) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else if (clr_i) begin
      // Any popped-but-undelivered beat is dropped along with the burst.
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start_i) begin
        remaining_q <= burst_len_i;
        count_q     <= '0;
      end
      if (fifo_pop_o) begin
        data_q      <= fifo_data_i;
        valid_q     <= 1'b1;
        remaining_q <= remaining_q - BurstWidth'(1);
      end else if (handoff) begin
        valid_q <= 1'b0;
      end
      if (handoff) count_q <= count_q + BurstWidth'(1);
    end
  end

  assign busy_o  = (state_q == READ) || (state_q == DRAIN);
  assign done_o  = (state_q == DONE);
  assign count_o = count_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: expected beats queued by stimulus, checked by a monitor.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          busy, done;
  logic [BW-1:0] count;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready = 1'b1;

  // Registered source FIFO model: a push becomes visible the cycle after it is driven.
  logic [DW-1:0] mem [16];
  int unsigned   wr = 0, rd = 0;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          flush = 1'b0;

  assign fifo_empty = (wr == rd);
  assign fifo_data  = mem[rd[3:0]];

  always @(posedge clk) begin
    if (flush) rd <= wr;
    else if (fifo_pop) rd <= rd + 1;
    if (push_en) begin
      mem[wr[3:0]] <= push_data;
      wr <= wr + 1;
    end
  end

  fifo_burst_reader #(
    .DataWidth(DW),
    .MaxBurst (256)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .start_i     (start),
    .burst_len_i (burst_len),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .fifo_pop_o  (fifo_pop),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard and event logs written by the monitor.
  logic [DW-1:0] exp_q[$];
  int pop_cyc[$];
  int beat_cyc[$];
  int pop_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (prev_stall) check_eq("hold_data", {valid, data}, {1'b1, prev_data});
    if (fifo_pop) begin
      check_eq("pop_when_empty", fifo_empty, 0);
      check_eq("pop_during_stall", valid & ~ready, 0);
      pop_cnt++;
      pop_cyc.push_back(cyc - base);
    end
    if (valid && ready && rst_n && !clr) begin
      beat_cyc.push_back(cyc - base);
      if (exp_q.size() == 0) check_eq("unexpected_beat", data, 32'hDEAD_BEEF);
      else check_eq("beat_data", data, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - base;
    end
    prev_stall = valid && !ready && !clr && rst_n;
    prev_data  = data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    push_en   = 1'b1;
    push_data = d;
    tick();
    push_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic start_burst(input int len);
    start     = 1'b1;
    burst_len = BW'(len);
    base      = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > d0) break;
      tick();
    end
    check_eq("done_seen", done_cnt > d0, 1);
  endtask

  int p0, b0, d0;

  initial begin
    // 1: reset held with start asserted and data in the FIFO
    rst_n = 1'b0; start = 1'b1; burst_len = 3;
    push_en = 1'b1; push_data = 32'h55;
    tick();
    push_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_valid", valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pop", fifo_pop, 0);
      check_eq("rst_count", count, 0);
      check_eq("rst_data", data, 0);
      if (i == 0) tick();
    end
    rst_n = 1'b1; start = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);
    do_flush();

    // 2: burst of 4 out of 6 entries, no backpressure
    for (int i = 0; i < 6; i++) push(32'hA0 + i);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    ready = 1'b1;
    p0 = pop_cyc.size(); b0 = beat_cyc.size(); d0 = done_cnt;
    start_burst(4);
    wait_done(d0, 20);
    tick(); tick(); tick();
    check_eq("t2_pops", pop_cyc.size() - p0, 4);
    for (int i = 0; i < 4; i++) check_eq("t2_pop_cycle", pop_cyc[p0 + i], i + 1);
    check_eq("t2_first_beat", beat_cyc[b0], 2);
    check_eq("t2_last_beat", beat_cyc[b0 + 3], 5);
    check_eq("t2_done_cycle", done_cyc, 7);
    check_eq("t2_done_count", done_cnt - d0, 1);
    check_eq("t2_count", count, 4);
    check_eq("t2_fifo_left", wr - rd, 2);
    check_eq("t2_sb_empty", exp_q.size(), 0);
    do_flush();

    // 3: burst of 3 with ready toggling 1,0,1,0,...
    for (int i = 0; i < 3; i++) push(32'hA0 + i);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'hA0 + i);
    d0 = done_cnt; p0 = pop_cnt;
    ready = 1'b1; start = 1'b1; burst_len = 3; base = cyc;
    for (int i = 0; i < 20; i++) begin
      tick();
      start = 1'b0;
      ready = (i % 2 == 1);
    end
    ready = 1'b1;
    tick();
    check_eq("t3_pops", pop_cnt - p0, 3);
    check_eq("t3_done_count", done_cnt - d0, 1);
    check_eq("t3_count", count, 3);
    check_eq("t3_sb_empty", exp_q.size(), 0);
    do_flush();

    // 4: starved FIFO, entries trickle in at cycles 5 and 9
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h22);
    p0 = pop_cyc.size(); d0 = done_cnt;
    start_burst(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t4_busy_starved", busy, 1);
    end
    push(32'h11);
    check_eq("t4_busy_mid", busy, 1);
    tick(); tick(); tick();
    check_eq("t4_busy_wait2", busy, 1);
    push(32'h22);
    wait_done(d0, 20);
    tick(); tick();
    check_eq("t4_pops", pop_cyc.size() - p0, 2);
    check_eq("t4_pop0_cycle", pop_cyc[p0], 6);
    check_eq("t4_pop1_cycle", pop_cyc[p0 + 1], 10);
    check_eq("t4_done_count", done_cnt - d0, 1);
    check_eq("t4_count", count, 2);

    // 5a: zero-length burst
    do_flush();
    p0 = pop_cnt; d0 = done_cnt;
    start_burst(0);
    tick(); tick(); tick();
    check_eq("t5_zero_done_count", done_cnt - d0, 1);
    check_eq("t5_zero_done_cycle", (done_cyc >= 1) && (done_cyc <= 2), 1);
    check_eq("t5_zero_pops", pop_cnt - p0, 0);
    check_eq("t5_zero_count", count, 0);

    // 5b: start pulse during READ must not reload the remaining count
    exp_q.push_back(32'h31);
    exp_q.push_back(32'h32);
    p0 = pop_cnt; d0 = done_cnt;
    start_burst(2);
    tick();
    start = 1'b1; burst_len = 5;
    tick();
    start = 1'b0;
    push(32'h31);
    push(32'h32);
    push(32'h33);
    wait_done(d0, 20);
    tick(); tick(); tick();
    check_eq("t5_pops", pop_cnt - p0, 2);
    check_eq("t5_count", count, 2);
    check_eq("t5_fifo_left", wr - rd, 1);
    check_eq("t5_sb_empty", exp_q.size(), 0);
    do_flush();

    // 6: abort after two beats, then a 1-beat burst picks up the next entry
    for (int i = 0; i < 6; i++) push(32'hB0 + i);
    exp_q.push_back(32'hB0);
    exp_q.push_back(32'hB1);
    ready = 1'b1; d0 = done_cnt;
    start_burst(5);
    for (int i = 0; i < 20; i++) begin
      if (count == 2) break;
      tick();
    end
    check_eq("t6_reached_two", count, 2);
    clr = 1'b1; ready = 1'b0;
    tick();
    clr = 1'b0;
    check_eq("t6_clr_busy", busy, 0);
    check_eq("t6_clr_valid", valid, 0);
    check_eq("t6_clr_count", count, 0);
    check_eq("t6_clr_done", done, 0);
    ready = 1'b1;
    tick(); tick(); tick();
    check_eq("t6_no_done", done_cnt - d0, 0);
    check_eq("t6_sb_empty", exp_q.size(), 0);
    exp_q.push_back(32'hB3);
    start_burst(1);
    wait_done(d0, 20);
    tick(); tick();
    check_eq("t6_follow_count", count, 1);
    check_eq("t6_follow_done", done_cnt - d0, 1);
    check_eq("t6_fifo_left", wr - rd, 2);
    check_eq("t6_follow_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
